// File: rtl/vga_pkg.sv
// Shared VGA scanout definitions: default 640x480@60 timing, frame-buffer
// geometry, clear-engine state type, sync bundle and pixel colour expansion.
package vga_pkg;

  // Default horizontal timing, in pixel ticks
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800

  // Default vertical timing, in lines
  localparam int DEF_V_VIS   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

  localparam int FB_DEPTH = DEF_H_VIS * DEF_V_VIS;  // 307200
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 6;

  typedef enum logic {IDLE, SWEEP} clr_state_t;

  // Sync/blank bundle carried down the output pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  // {r,g,b} 2 bits each -> 8 bits each by replicating the 2-bit field
  function automatic logic [23:0] expand_rgb(input logic [PIX_W-1:0] p);
    return {{4{p[5:4]}}, {4{p[3:2]}}, {4{p[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-tick divider, h/v counters, raw (undelayed)
// hsync/vsync/blank and the linear frame-buffer read address.
// Ports: clk, rst_n (async low); pix_en (1 clk in every CLK_DIV);
//        hs, vs (active low), blank_n (visible region); rd_addr.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              pix_en,
  output logic              hs,
  output logic              vs,
  output logic              blank_n,
  output logic [ADDR_W-1:0] rd_addr
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hcnt, vcnt;
  logic             h_last, v_last, visible;

  assign pix_en  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last  = (hcnt == 10'(H_TOT - 1));
  assign v_last  = (vcnt == 10'(V_TOT - 1));
  assign visible = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));

  assign hs      = !((hcnt >= 10'(H_VIS + H_FP)) && (hcnt < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs      = !((vcnt >= 10'(V_VIS + V_FP)) && (vcnt < 10'(V_VIS + V_FP + V_SYNC)));
  assign blank_n = visible;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  // rd_addr always points at the pixel of the current counters: it steps
  // after each visible pixel (so it already holds the next line's start
  // through h-blank) and restarts only on the wrap into (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      rd_addr <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (h_last && v_last) rd_addr <= '0;
      else if (visible)     rd_addr <= rd_addr + 1'b1;
    end
  end

endmodule

// File: rtl/video_scanout.sv
// Frame buffer + VGA scanout. Accepts the placer pixel stream into a
// H_VIS*V_VIS x 6 RAM, scans it out with 2-tick aligned sync/blank and
// expands pixels to 24-bit RGB. A clear engine zeroes the whole buffer.
// Ports: clk, rst_n (async low); waddr/wdata/we placer write; clr_req pulse,
//        clr_busy; frame_start pulse at vsync fall; VGA_R/G/B, VGA_HS/VS
//        (active low), VGA_BLANK_N.
module video_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              we,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              frame_start,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N
);

  localparam int FB    = H_VIS * V_VIS;
  localparam int FB_AW = $clog2(FB);
  localparam int PIPE  = 2;  // RAM read tick + colour register tick

  logic              pix_en;
  sync_t             raw_sync;
  logic [ADDR_W-1:0] rd_addr;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_en  (pix_en),
    .hs      (raw_sync.hs),
    .vs      (raw_sync.vs),
    .blank_n (raw_sync.blank_n),
    .rd_addr (rd_addr)
  );

  // ---------------- clear engine ----------------
  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // clr_req while sweeping is deliberately ignored so busy cannot be extended
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      IDLE: if (clr_req) begin
        state_nxt    = SWEEP;
        clr_addr_nxt = '0;
      end
      SWEEP: begin
        if (clr_addr == ADDR_W'(FB - 1)) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == SWEEP);

  // ---------------- write arbitration ----------------
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [PIX_W-1:0]  ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = waddr;
    ram_wdata = wdata;
    if (clr_busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end else if (we && (waddr < ADDR_W'(FB))) begin
      ram_we = 1'b1;
    end
  end

  // ---------------- frame buffer ----------------
  // Read is sampled once per pixel tick so rd_data holds the pixel of the
  // previous tick's counters until the colour register takes it.
  // Same-address write/read in one clk returns the old contents.
  logic [PIX_W-1:0] mem [FB];
  logic [PIX_W-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr[FB_AW-1:0]] <= ram_wdata;
    if (pix_en) rd_data <= mem[rd_addr[FB_AW-1:0]];
  end

  // ---------------- output pipeline ----------------
  sync_t [PIPE:1] sync_pipe;
  logic  [23:0]   rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe   <= {PIPE{SYNC_RST}};
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      // fires on the same edge that drops the delayed vsync
      frame_start <= pix_en && sync_pipe[PIPE].vs && !sync_pipe[PIPE-1].vs;
      if (pix_en) begin
        sync_pipe <= {sync_pipe[PIPE-1:1], raw_sync};
        rgb       <= sync_pipe[1].blank_n ? expand_rgb(rd_data) : 24'h0;
      end
    end
  end

  assign VGA_HS      = sync_pipe[PIPE].hs;
  assign VGA_VS      = sync_pipe[PIPE].vs;
  assign VGA_BLANK_N = sync_pipe[PIPE].blank_n;
  assign VGA_R       = rgb[23:16];
  assign VGA_G       = rgb[15:8];
  assign VGA_B       = rgb[7:0];

endmodule
